// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES (Inv)SubBytes engine: LANES S-box lookups per cycle over the 16-byte state.
// Define SUB_BYTES_FWD_EN to build the forward table and honour in_inv; otherwise decrypt-only (InvS always).
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N_STEPS = 16 / LANES;
  localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [127:0]        r_data;
  logic [127:0]        w_data_next;
  logic [STEP_W-1:0]   r_step;
  logic                w_last_step;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

`ifdef SUB_BYTES_FWD_EN
  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic r_inv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_inv <= 1'b0;
    else if (r_state == S_IDLE && in_valid)
      r_inv <= in_inv;
  end
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
`endif

  assign w_last_step = (r_step == STEP_W'(N_STEPS - 1));
  assign out_state   = r_data;

  // Lanes cover bytes [step*LANES +: LANES]; untouched bytes pass through unchanged.
  always_comb begin
    w_data_next = r_data;
    for (int l = 0; l < LANES; l++) begin
`ifdef SUB_BYTES_FWD_EN
      w_data_next[(int'(r_step) * LANES + l) * 8 +: 8] =
        r_inv ? INV_SBOX[r_data[(int'(r_step) * LANES + l) * 8 +: 8]]
              : FWD_SBOX[r_data[(int'(r_step) * LANES + l) * 8 +: 8]];
`else
      w_data_next[(int'(r_step) * LANES + l) * 8 +: 8] =
        INV_SBOX[r_data[(int'(r_step) * LANES + l) * 8 +: 8]];
`endif
    end
  end

  // Handshake outputs decode only the state register, so no input reaches an output combinationally.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next_state = S_BUSY;
      end
      S_BUSY: begin
        if (w_last_step) w_next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        busy         = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: the data register is reset too, so an aborted block leaves no partial result on out_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data <= in_state;
            r_step <= '0;
          end
        end
        S_BUSY: begin
          r_data <= w_data_next;
          r_step <= r_step + STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: four instances (LANES 1, 2, 4, 16) share stimulus and are each
// compared every cycle against a byte-level model built from GF(2^8) arithmetic.
module tb_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b1;

  logic [3:0]   in_ready_v;
  logic [3:0]   out_valid_v;
  logic [3:0]   busy_v;
  logic [127:0] out_state_v [4];

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Expected state after the first nbytes bytes have been substituted.
  function automatic logic [127:0] model_sub(input logic [127:0] s, input logic inv, input int nbytes);
    logic [127:0] r = s;
    for (int k = 0; k < 16; k++)
      if (k < nbytes) r[8*k +: 8] = inv ? inv_t[s[8*k +: 8]] : fwd_t[s[8*k +: 8]];
    return r;
  endfunction

  function automatic int lanes_of(input int g);
    return (g == 3) ? 16 : (1 << g);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int L = (g == 3) ? 16 : (1 << g);
    localparam int N = 16 / L;

    sub_bytes_engine #(.LANES(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .in_state  (in_state),
      .in_inv    (in_inv),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .out_state (out_state_v[g]),
      .busy      (busy_v[g])
    );

    bit           m_busy  = 1'b0;
    int           m_steps = 0;
    logic [127:0] m_in    = '0;
    logic         m_inv   = 1'b0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        m_busy  <= 1'b0;
        m_steps <= 0;
        m_in    <= '0;
        m_inv   <= 1'b0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy  <= 1'b1;
          m_steps <= 0;
          m_in    <= in_state;
`ifdef SUB_BYTES_FWD_EN
          m_inv   <= in_inv;
`else
          m_inv   <= 1'b1;
`endif
        end
      end else if (m_steps < N) begin
        m_steps <= m_steps + 1;
      end else if (out_ready) begin
        m_busy <= 1'b0;
      end
    end

    always @(negedge clk) begin
      check($sformatf("L%0d in_ready", L), 128'(in_ready_v[g]), 128'(!m_busy));
      check($sformatf("L%0d out_valid", L), 128'(out_valid_v[g]), 128'(m_busy && m_steps == N));
      check($sformatf("L%0d busy", L), 128'(busy_v[g]), 128'(m_busy));
      check($sformatf("L%0d out_state", L), out_state_v[g], model_sub(m_in, m_inv, m_steps * L));
    end
  end

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 300; c++) begin
      if (&in_ready_v) break;
      @(posedge clk); #1;
    end
    check({tag, " idle wait"}, 128'(in_ready_v), 128'(4'hf));
  endtask

  // Issue one block to all instances and verify each one's acceptance-to-out_valid latency.
  task automatic send(input logic [127:0] s, input logic inv, input bit rand_ready);
    int lat [4];
    bit all_seen;
    wait_idle("send");
    in_valid = 1'b1;
    in_state = s;
    in_inv   = inv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = rand128();
    in_inv   = 1'($urandom);
    for (int g = 0; g < 4; g++) lat[g] = 0;
    for (int c = 1; c <= 300; c++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      all_seen = 1'b1;
      for (int g = 0; g < 4; g++) begin
        if (out_valid_v[g] && lat[g] == 0) lat[g] = c;
        if (lat[g] == 0) all_seen = 1'b0;
      end
      if (all_seen && &in_ready_v) break;
    end
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++)
      check($sformatf("L%0d latency", lanes_of(g)), 128'(lat[g]), 128'(16 / lanes_of(g)));
  endtask

  initial begin
    logic [127:0] fips_in;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      fwd_t[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);

    check("model S(00)", 128'(fwd_t[8'h00]), 128'(8'h63));
    check("model S(53)", 128'(fwd_t[8'h53]), 128'(8'hed));
    check("model InvS(63)", 128'(inv_t[8'h63]), 128'(8'h00));
    check("model InvS(52)", 128'(inv_t[8'h52]), 128'(8'h48));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset in_ready", 128'(in_ready_v), 128'(4'hf));
    check("reset out_valid", 128'(out_valid_v), 128'(4'h0));
    check("reset busy", 128'(busy_v), 128'(4'h0));
    check("reset out_state", out_state_v[2], 128'd0);

    send(128'd0, 1'b0, 1'b0);
`ifdef SUB_BYTES_FWD_EN
    check("L4 fwd zero", out_state_v[2], {16{8'h63}});
`else
    check("L4 inv-only zero", out_state_v[2], {16{8'h52}});
`endif

    send({16{8'h63}}, 1'b1, 1'b0);
    check("L16 inv 63", out_state_v[3], 128'd0);
    send({16{8'h52}}, 1'b1, 1'b0);
    check("L16 inv 52", out_state_v[3], {16{8'h48}});
    send({16{8'hed}}, 1'b1, 1'b0);
    check("L1 inv ed", out_state_v[0], {16{8'h53}});

`ifdef SUB_BYTES_FWD_EN
    fips_in = 128'h00112233445566778899aabbccddeeff;
    send(fips_in, 1'b0, 1'b0);
    check("L1 fips fwd", out_state_v[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
    send(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 1'b0);
    check("L1 fips round trip", out_state_v[0], fips_in);
    send({16{8'h53}}, 1'b0, 1'b0);
    check("L1 fwd 53", out_state_v[0], {16{8'hed}});
`else
    fips_in = '0;
    send({16{8'h63}}, 1'b0, 1'b0);
    check("L4 in_inv ignored", out_state_v[2] | fips_in, 128'd0);
`endif

    // Backpressure: hold results in DONE while the inputs churn.
    wait_idle("bp");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = rand128();
    in_inv    = 1'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !(&out_valid_v); c++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom);
      in_state = rand128();
      in_inv   = 1'($urandom);
      @(posedge clk); #1;
      check("bp out_valid held", 128'(out_valid_v), 128'(4'hf));
      check("bp in_ready low", 128'(in_ready_v), 128'(4'h0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle("bp release");

    // Reset at step 2 of a LANES=2 block.
    in_valid = 1'b1;
    in_state = rand128();
    in_inv   = 1'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("mid reset L2 out_valid", 128'(out_valid_v[1]), 128'd0);
    check("mid reset L2 out_state", out_state_v[1], 128'd0);
    check("mid reset L2 busy", 128'(busy_v[1]), 128'd0);
    check("mid reset L2 in_ready", 128'(in_ready_v[1]), 128'd1);
    reset = 1'b0;
    send(rand128(), 1'($urandom), 1'b0);

    // Continuous in_valid: each instance runs back to back at its own block period.
    for (int c = 0; c < 60; c++) begin
      in_valid = 1'b1;
      in_state = rand128();
      in_inv   = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle("stream");

    repeat (12) send(rand128(), 1'($urandom), 1'b1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
